// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// small constant/bitwise helpers used to size and step the bit counter.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int clog2_min1(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

   // Ripple increment built from XOR/AND so the only adder in the block is the cell
   function automatic logic [31:0] bit_inc(input logic [31:0] v);
      logic [31:0] r;
      logic        c;
      c = 1'b1;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[i] ^ c;
         c    = v[i] & c;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell shared across all bit positions of the serial adder.
module Full_Adder (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one Full_Adder,
// carry is held in a flop between steps, result offered on a valid/ready port.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = clog2_min1(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co;
   logic             load, last;

   Full_Adder u_fa (
      .s    (fa_s),
      .cout (fa_co),
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nx    = state;
      start_ready = 1'b0;
      load        = 1'b0;
      case (state)
         ST_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            // Consumer taking the result frees the slot in the same cycle
            if (done_ready) begin
               start_ready = 1'b1;
               if (start_valid) begin
                  load     = 1'b1;
                  state_nx = ST_RUN;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry  <= fa_co;
            // Hold at the final count rather than wrapping
            if (!last) cnt <= CW'(bit_inc(32'(cnt)));
         end
      end
   end

   assign sum        = sum_sr;
   assign cout       = carry;
   assign done_valid = (state == ST_DONE);
   assign busy       = (state == ST_RUN);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed checks of serial_adder_ctrl (WIDTH=8 and WIDTH=1)
// against plain integer addition.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic       sv8, sr8, dv8, dr8, cin8, co8, busy8;
   logic [7:0] a8, b8, sum8;
   logic       sv1, sr1, dv1, dr1, cin1, co1, busy1;
   logic [0:0] a1, b1, sum1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
      .a(a8), .b(b8), .cin(cin8), .done_valid(dv8), .done_ready(dr8),
      .sum(sum8), .cout(co8), .busy(busy8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
      .a(a1), .b(b1), .cin(cin1), .done_valid(dv1), .done_ready(dr1),
      .sum(sum1), .cout(co1), .busy(busy1)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_rdy8(output int t);
      int n = 0;
      while (!sr8 && n < 50) begin @(negedge clk); n++; end
      chk("start_to", 32'(n < 50), 1);
      t = cyc;
   endtask

   task automatic wait_dv8();
      int n = 0;
      while (!dv8 && n < 50) begin @(negedge clk); n++; end
      chk("done_to", 32'(n < 50), 1);
   endtask

   // One WIDTH=8 transaction; operand ports are scrambled right after the handshake
   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input int hold);
      int         t0;
      logic [8:0] exp;
      exp  = 9'({1'b0, ia} + {1'b0, ib} + 9'(ic));
      dr8  = (hold == 0);
      sv8  = 1'b1; a8 = ia; b8 = ib; cin8 = ic;
      wait_rdy8(t0);
      @(negedge clk);
      sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      wait_dv8();
      chk("lat8", cyc - t0, 9);
      chk("sum8", 32'(sum8), 32'(exp[7:0]));
      chk("cout8", 32'(co8), 32'(exp[8]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_vld", 32'(dv8), 1);
         chk("bp_sum", 32'(sum8), 32'(exp[7:0]));
         chk("bp_cout", 32'(co8), 32'(exp[8]));
         chk("bp_rdy", 32'(sr8), 0);
      end
      dr8 = 1'b1;
      @(negedge clk);
      chk("ack_vld", 32'(dv8), 0);
   endtask

   task automatic op1(input logic ia, input logic ib, input logic ic);
      int         t0, n;
      logic [1:0] exp;
      exp = 2'(ia) + 2'(ib) + 2'(ic);
      sv1 = 1'b1; a1 = ia; b1 = ib; cin1 = ic;
      n = 0;
      while (!sr1 && n < 20) begin @(negedge clk); n++; end
      chk("start1_to", 32'(n < 20), 1);
      t0 = cyc;
      @(negedge clk);
      sv1 = 1'b0; a1 = ~ia; b1 = ~ib; cin1 = ~ic;
      n = 0;
      while (!dv1 && n < 20) begin @(negedge clk); n++; end
      chk("lat1", cyc - t0, 2);
      chk("res1", 32'({co1, sum1}), 32'(exp));
      @(negedge clk);
   endtask

   initial begin
      int         t0;
      logic [7:0] ra, rb;
      rst_n = 1'b0;
      sv8 = 0; a8 = 0; b8 = 0; cin8 = 0; dr8 = 1;
      sv1 = 0; a1 = 0; b1 = 0; cin1 = 0; dr1 = 1;
      repeat (2) @(negedge clk);
      chk("rst_vld", 32'(dv8), 0);
      chk("rst_sum", 32'(sum8), 0);
      chk("rst_cout", 32'(co8), 0);
      chk("rst_busy", 32'(busy8), 0);
      chk("rst_rdy", 32'(sr8), 1);
      rst_n = 1'b1;
      @(negedge clk);

      op8(8'h3C, 8'h05, 1'b0, 0);
      op8(8'hFF, 8'h01, 1'b0, 0);
      op8(8'hFF, 8'hFF, 1'b1, 0);
      op8(8'hA5, 8'h5A, 1'b1, 5);

      // Start held through RUN and a stalled DONE, then accepted back-to-back
      dr8 = 1'b0;
      sv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
      wait_rdy8(t0);
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("run_rdy", 32'(sr8), 0);
         chk("run_busy", 32'(busy8), 1);
         @(negedge clk);
      end
      chk("hold_vld", 32'(dv8), 1);
      chk("hold_lat", cyc - t0, 9);
      chk("hold_sum", 32'(sum8), 32'h47);
      chk("hold_cout", 32'(co8), 0);
      repeat (2) begin
         @(negedge clk);
         chk("hold_rdy", 32'(sr8), 0);
         chk("hold_sum2", 32'(sum8), 32'h47);
      end
      dr8 = 1'b1;
      #1;
      chk("b2b_rdy", 32'(sr8), 1);
      t0 = cyc;
      @(negedge clk);
      sv8 = 1'b0;
      chk("b2b_busy", 32'(busy8), 1);
      wait_dv8();
      chk("b2b_lat", cyc - t0, 9);
      chk("b2b_sum", 32'(sum8), 0);
      chk("b2b_cout", 32'(co8), 1);
      @(negedge clk);

      // Reset at RUN bit 3 drops the operation
      sv8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1;
      wait_rdy8(t0);
      @(negedge clk);
      sv8 = 1'b0;
      while (cyc < t0 + 4) @(negedge clk);
      chk("pre_rst_busy", 32'(busy8), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_vld", 32'(dv8), 0);
      chk("mid_rst_sum", 32'(sum8), 0);
      chk("mid_rst_cout", 32'(co8), 0);
      chk("mid_rst_busy", 32'(busy8), 0);
      chk("mid_rst_rdy", 32'(sr8), 1);
      op8(8'h01, 8'h01, 1'b0, 0);

      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         op8(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         op1(v[2], v[1], v[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
